// File: rtl/vx_dram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vx_dram_arb_pkg
// Description : Shared constants and tag-width helper for the per-core DRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package vx_dram_arb_pkg;

    localparam int ICACHE_REQ_IDX = 0;
    localparam int DCACHE_REQ_IDX = 1;

    // DRAM-side tag carries the requester index in its LSBs.
    function automatic int dram_tag_width(input int tag_in_width, input int num_reqs);
        return tag_in_width + $clog2(num_reqs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vx_elastic_buffer.sv
`default_nettype none
// ============================================================================
// Module      : vx_elastic_buffer
// Description : Small ready/valid FIFO; accepts a push while full if a pop occurs.
// Revision    : 1.0 - initial release
// ============================================================================
module vx_elastic_buffer #(
    parameter int SIZE  = 2,
    parameter int DATAW = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [DATAW-1:0] data_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [DATAW-1:0] data_out
);

    localparam int c_ptr_w = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int c_cnt_w = $clog2(SIZE + 1);

    logic [DATAW-1:0]   r_mem [SIZE];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_full;
    logic               w_push;
    logic               w_pop;

    function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(SIZE - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_full    = (r_count == c_cnt_w'(SIZE));
    assign valid_out = (r_count != '0);
    assign ready_in  = !w_full || ready_out;
    assign w_push    = valid_in && ready_in;
    assign w_pop     = valid_out && ready_out;
    assign data_out  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= data_in;
    end

endmodule
`default_nettype wire

// File: rtl/vx_dram_arb.sv
`default_nettype none
// ============================================================================
// Module      : vx_dram_arb
// Description : Round-robin merge of icache/dcache DRAM requests, tag-routed responses.
// Revision    : 1.0 - initial release
// ============================================================================
module vx_dram_arb
    import vx_dram_arb_pkg::*;
#(
    parameter  int NUM_REQS      = 2,
    parameter  int DATA_WIDTH    = 128,
    parameter  int ADDR_WIDTH    = 28,
    parameter  int TAG_IN_WIDTH  = 8,
    localparam int TAG_OUT_WIDTH = dram_tag_width(TAG_IN_WIDTH, NUM_REQS)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQS-1:0]                 in_req_valid,
    input  logic [NUM_REQS-1:0]                 in_req_rw,
    input  logic [NUM_REQS*DATA_WIDTH/8-1:0]    in_req_byteen,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]      in_req_addr,
    input  logic [NUM_REQS*DATA_WIDTH-1:0]      in_req_data,
    input  logic [NUM_REQS*TAG_IN_WIDTH-1:0]    in_req_tag,
    output logic [NUM_REQS-1:0]                 in_req_ready,
    output logic                                out_req_valid,
    output logic                                out_req_rw,
    output logic [DATA_WIDTH/8-1:0]             out_req_byteen,
    output logic [ADDR_WIDTH-1:0]               out_req_addr,
    output logic [DATA_WIDTH-1:0]               out_req_data,
    output logic [TAG_OUT_WIDTH-1:0]            out_req_tag,
    input  logic                                out_req_ready,
    input  logic                                out_rsp_valid,
    input  logic [DATA_WIDTH-1:0]               out_rsp_data,
    input  logic [TAG_OUT_WIDTH-1:0]            out_rsp_tag,
    output logic                                out_rsp_ready,
    output logic [NUM_REQS-1:0]                 in_rsp_valid,
    output logic [NUM_REQS*DATA_WIDTH-1:0]      in_rsp_data,
    output logic [NUM_REQS*TAG_IN_WIDTH-1:0]    in_rsp_tag,
    input  logic [NUM_REQS-1:0]                 in_rsp_ready
);

    localparam int c_idx_w     = $clog2(NUM_REQS);
    localparam int c_be_w      = DATA_WIDTH / 8;
    localparam int c_payload_w = 1 + c_be_w + ADDR_WIDTH + DATA_WIDTH + TAG_OUT_WIDTH;

    logic [c_idx_w-1:0]      r_rr_ptr;
    logic [c_idx_w-1:0]      w_grant_idx;
    logic                    w_found;
    logic                    w_grant_fire;
    logic                    w_buf_ready;
    int                      w_best;
    int                      w_dist;
    logic                    w_sel_rw;
    logic [c_be_w-1:0]       w_sel_byteen;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic [TAG_IN_WIDTH-1:0] w_sel_tag;
    logic [c_payload_w-1:0]  w_push_payload;
    logic [c_payload_w-1:0]  w_head_payload;

    // Priority is the distance from the rr pointer, so the search wraps naturally.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_best      = NUM_REQS;
        w_dist      = 0;
        for (int i = 0; i < NUM_REQS; i++) begin
            w_dist = (i + NUM_REQS - int'(r_rr_ptr)) % NUM_REQS;
            if (in_req_valid[i] && (w_dist < w_best)) begin
                w_best      = w_dist;
                w_grant_idx = c_idx_w'(i);
                w_found     = 1'b1;
            end
        end
    end

    assign w_grant_fire = w_found && w_buf_ready;

    always_comb begin
        in_req_ready = '0;
        w_sel_rw     = 1'b0;
        w_sel_byteen = '0;
        w_sel_addr   = '0;
        w_sel_data   = '0;
        w_sel_tag    = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (w_grant_idx == c_idx_w'(i)) begin
                in_req_ready[i] = w_grant_fire;
                w_sel_rw        = in_req_rw[i];
                w_sel_byteen    = in_req_byteen[i*c_be_w +: c_be_w];
                w_sel_addr      = in_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_data      = in_req_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_tag       = in_req_tag[i*TAG_IN_WIDTH +: TAG_IN_WIDTH];
            end
        end
    end

    assign w_push_payload = {w_sel_rw, w_sel_byteen, w_sel_addr, w_sel_data, w_sel_tag, w_grant_idx};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_grant_fire) begin
            r_rr_ptr <= (w_grant_idx == c_idx_w'(NUM_REQS - 1)) ? '0 : w_grant_idx + 1'b1;
        end
    end

    vx_elastic_buffer #(
        .SIZE  (2),
        .DATAW (c_payload_w)
    ) u_req_buf (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (w_found),
        .ready_in  (w_buf_ready),
        .data_in   (w_push_payload),
        .valid_out (out_req_valid),
        .ready_out (out_req_ready),
        .data_out  (w_head_payload)
    );

    assign {out_req_rw, out_req_byteen, out_req_addr, out_req_data, out_req_tag} = w_head_payload;

    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_data;
    logic [TAG_IN_WIDTH-1:0] r_rsp_tag;
    logic [c_idx_w-1:0]      r_rsp_sel;
    logic [c_idx_w-1:0]      w_rsp_sel;
    logic                    w_sel_legal;
    logic                    w_q_ready;
    logic                    w_rsp_fire;

    assign w_rsp_sel = out_rsp_tag[c_idx_w-1:0];

    always_comb begin
        w_sel_legal = 1'b0;
        w_q_ready   = 1'b0;
        for (int k = 0; k < NUM_REQS; k++) begin
            if (w_rsp_sel == c_idx_w'(k)) w_sel_legal = 1'b1;
            if (r_rsp_sel == c_idx_w'(k)) w_q_ready   = in_rsp_ready[k];
        end
    end

    assign out_rsp_ready = !r_rsp_valid || w_q_ready;
    assign w_rsp_fire    = out_rsp_valid && out_rsp_ready;

    // An out-of-range index is accepted from DRAM but never presented to a cache.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
        end else if (w_rsp_fire) begin
            r_rsp_valid <= w_sel_legal;
        end else if (w_q_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rsp_fire) begin
            r_rsp_data <= out_rsp_data;
            r_rsp_tag  <= out_rsp_tag[TAG_OUT_WIDTH-1:c_idx_w];
            r_rsp_sel  <= w_rsp_sel;
        end
    end

    generate
        for (genvar k = 0; k < NUM_REQS; k++) begin : g_rsp_lane
            assign in_rsp_valid[k]                              = r_rsp_valid && (r_rsp_sel == c_idx_w'(k));
            assign in_rsp_data[k*DATA_WIDTH +: DATA_WIDTH]      = r_rsp_data;
            assign in_rsp_tag[k*TAG_IN_WIDTH +: TAG_IN_WIDTH]   = r_rsp_tag;
        end
    endgenerate

    a_rsp_sel_legal: assert property (@(posedge clk) disable iff (reset)
        w_rsp_fire |-> w_sel_legal);

endmodule
`default_nettype wire
